hash_mem_responder: RTL and testbench

Memory-side responder for the hash engines' memory interface. It serves the engine's word reads with one-cycle registered latency and accepts engine writes. A host load/readback port preloads block-header words and reads back digests. A result tracker watches engine writes into the digest window and raises a completion flag once every digest word has landed.

---
 rtl/hash_mem_responder.sv | 159 +++++++++++++++
 tb/tb_hash_mem_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_mem_responder.sv
// hash_mem_responder: word memory shared by a hash engine port (1-cycle
// registered read, read-first write) and a host load/readback port, plus a
// tracker that flags when every digest word in the result window is written.
//
// Host handshake: host_req is held by the host until it sees host_ack; the
// request fields are latched when the request is accepted in H_IDLE, host_ack
// is a one-cycle pulse, and host_rdata is valid only while host_ack is high.
module hash_mem_responder #(
    parameter int          DEPTH        = 1024,
    parameter int          RESULT_WORDS = 16,
    parameter logic [31:0] OOR_DATA     = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [15:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        host_ack,
    input  logic [15:0] result_base,
    input  logic        result_clear,
    output logic [4:0]  result_count,
    output logic        result_valid,
    output logic        addr_err
);

    localparam int          AW        = $clog2(DEPTH);
    localparam int          IW        = $clog2(RESULT_WORDS);
    localparam logic [16:0] DEPTH_EXT = 17'(DEPTH);
    localparam logic [16:0] WORDS_EXT = 17'(RESULT_WORDS);
    localparam logic [4:0]  COUNT_FULL = 5'(RESULT_WORDS);

    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        H_WAIT = 2'd1,
        H_ACK  = 2'd2
    } host_state_t;

    host_state_t state;
    logic        h_we;
    logic [15:0] h_addr;
    logic [31:0] h_wdata;

    logic [31:0] mem [DEPTH];

    logic                    eng_in_range;
    logic                    host_in_range;
    logic                    host_done;
    logic                    host_wr;
    logic [16:0]             win_idx;
    logic                    win_hit;
    logic [IW-1:0]           win_bit;
    logic [RESULT_WORDS-1:0] written;

    // Address decode, host completion and digest-window hit (17-bit so no wrap)
    always_comb begin
        eng_in_range  = {1'b0, mem_addr} < DEPTH_EXT;
        host_in_range = {1'b0, h_addr} < DEPTH_EXT;
        // The engine owns the write port; a host write waits while mem_we is high
        host_done     = (state == H_WAIT) && (!h_we || !mem_we);
        host_wr       = (state == H_WAIT) && h_we && !mem_we;
        win_idx       = {1'b0, mem_addr} - {1'b0, result_base};
        win_hit       = mem_we && eng_in_range &&
                        ({1'b0, mem_addr} >= {1'b0, result_base}) &&
                        (win_idx < WORDS_EXT);
        win_bit       = win_idx[IW-1:0];
    end

    // Single write port: engine first, then a pending host write; none in reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                if (eng_in_range) begin
                    mem[mem_addr[AW-1:0]] <= mem_write_data;
                end
            end else if (host_wr && host_in_range) begin
                mem[h_addr[AW-1:0]] <= h_wdata;
            end
        end
    end

    // Engine read every cycle, one-cycle registered, old data on a same-cycle write
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read_data <= '0;
        end else begin
            mem_read_data <= eng_in_range ? mem[mem_addr[AW-1:0]] : OOR_DATA;
        end
    end

    // Sticky flag for any out-of-range engine or host access
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_err <= 1'b0;
        end else if (!eng_in_range || (host_done && !host_in_range)) begin
            addr_err <= 1'b1;
        end
    end

    // Host port FSM: accept, perform (stalling behind engine writes), ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= H_IDLE;
            h_we       <= 1'b0;
            h_addr     <= '0;
            h_wdata    <= '0;
            host_rdata <= '0;
            host_ack   <= 1'b0;
        end else begin
            case (state)
                H_IDLE: begin
                    if (host_req) begin
                        h_we    <= host_we;
                        h_addr  <= host_addr;
                        h_wdata <= host_wdata;
                        state   <= H_WAIT;
                    end
                end
                H_WAIT: begin
                    if (!h_we) begin
                        host_rdata <= host_in_range ? mem[h_addr[AW-1:0]] : OOR_DATA;
                        host_ack   <= 1'b1;
                        state      <= H_ACK;
                    end else if (!mem_we) begin
                        host_ack <= 1'b1;
                        state    <= H_ACK;
                    end
                end
                H_ACK: begin
                    host_ack <= 1'b0;
                    state    <= H_IDLE;
                end
                default: begin
                    host_ack <= 1'b0;
                    state    <= H_IDLE;
                end
            endcase
        end
    end

    // Result tracker: count first engine write per window index; clear wins
    always_ff @(posedge clk) begin
        if (reset || result_clear) begin
            written      <= '0;
            result_count <= '0;
            result_valid <= 1'b0;
        end else if (win_hit && !written[win_bit]) begin
            written[win_bit] <= 1'b1;
            result_count     <= result_count + 5'd1;
            result_valid     <= (result_count + 5'd1) == COUNT_FULL;
        end
    end

endmodule

// File: tb/tb_hash_mem_responder.sv
// Directed bench for hash_mem_responder: host preload/readback, engine read
// latency and read-first behaviour, write-port arbitration, digest tracking,
// out-of-range handling and reset recovery.
module tb_hash_mem_responder;

    logic        clk;
    logic        reset;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        host_req;
    logic        host_we;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_ack;
    logic [15:0] result_base;
    logic        result_clear;
    logic [4:0]  result_count;
    logic        result_valid;
    logic        addr_err;

    int checks   = 0;
    int failures = 0;

    hash_mem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .host_req       (host_req),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_rdata     (host_rdata),
        .host_ack       (host_ack),
        .result_base    (result_base),
        .result_clear   (result_clear),
        .result_count   (result_count),
        .result_valid   (result_valid),
        .addr_err       (addr_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1 ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    // Preload pattern for addresses 0..18
    function automatic logic [31:0] pre(input int i);
        return 32'h11111111 + 32'(i) * 32'h00010001;
    endfunction

    // One host transaction; returns read data and ticks until ack was seen
    task automatic host_xfer(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output int lat);
        logic seen;
        seen       = 1'b0;
        lat        = 0;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        while (!seen && lat < 20) begin
            tick();
            lat++;
            if (host_ack) seen = 1'b1;
        end
        rdata    = host_rdata;
        host_req = 1'b0;
        chk("host_ack_seen", {31'b0, seen}, 32'd1);
        tick();
    endtask

    logic [31:0] rd;
    int          lat;
    logic        seen;
    logic [15:0] trk_addr [17] = '{16'h100, 16'h101, 16'h102, 16'h103, 16'h104, 16'h105,
                                   16'h105, 16'h106, 16'h107, 16'h108, 16'h109, 16'h10A,
                                   16'h10B, 16'h10C, 16'h10D, 16'h10E, 16'h10F};
    logic [4:0]  trk_cnt  [17] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd6, 5'd7, 5'd8,
                                   5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};

    initial begin
        // Reset
        reset          = 1'b1;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        host_req       = 1'b0;
        host_we        = 1'b0;
        host_addr      = '0;
        host_wdata     = '0;
        result_base    = 16'h100;
        result_clear   = 1'b0;
        repeat (3) tick();
        chk("rst_mem_read_data", mem_read_data, 32'h0);
        chk("rst_host_rdata", host_rdata, 32'h0);
        chk("rst_host_ack", {31'b0, host_ack}, 32'h0);
        chk("rst_result_count", {27'b0, result_count}, 32'h0);
        chk("rst_result_valid", {31'b0, result_valid}, 32'h0);
        chk("rst_addr_err", {31'b0, addr_err}, 32'h0);
        reset = 1'b0;
        tick();

        // Host preload of addresses 0..18, then engine reads one per cycle
        for (int i = 0; i < 19; i++) begin
            host_xfer(1'b1, 16'(i), pre(i), rd, lat);
            if (i == 0 || i == 18) chk("host_write_latency", 32'(lat), 32'd2);
        end
        for (int i = 0; i < 19; i++) begin
            mem_addr = 16'(i);
            tick();
            chk("engine_read_seq", mem_read_data, pre(i));
        end

        // Read-first on a same-cycle engine write/read of address 5
        host_xfer(1'b1, 16'd5, 32'hAAAA0000, rd, lat);
        mem_addr       = 16'd5;
        mem_we         = 1'b1;
        mem_write_data = 32'h5555FFFF;
        tick();
        chk("read_first_old", mem_read_data, 32'hAAAA0000);
        mem_we = 1'b0;
        tick();
        chk("read_first_new", mem_read_data, 32'h5555FFFF);

        // Host write to 0x20 stalled by three cycles of engine writes to 0x30
        host_req       = 1'b1;
        host_we        = 1'b1;
        host_addr      = 16'h20;
        host_wdata     = 32'hC0FFEE20;
        mem_we         = 1'b1;
        mem_addr       = 16'h30;
        mem_write_data = 32'h30303030;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            tick();
            lat++;
            if (lat == 4) mem_we = 1'b0;
            if (host_ack) seen = 1'b1;
        end
        host_req = 1'b0;
        chk("stall_ack_seen", {31'b0, seen}, 32'd1);
        chk("stall_latency", 32'(lat), 32'd5);
        tick();
        mem_addr = 16'h30;
        tick();
        chk("stall_engine_word", mem_read_data, 32'h30303030);
        mem_addr = 16'h20;
        tick();
        chk("stall_host_word", mem_read_data, 32'hC0FFEE20);
        host_xfer(1'b0, 16'h20, 32'h0, rd, lat);
        chk("host_readback_20", rd, 32'hC0FFEE20);

        // Host read of 7 while the engine writes 7 at the same edge
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 16'd7;
        tick();
        mem_we         = 1'b1;
        mem_addr       = 16'd7;
        mem_write_data = 32'h77777777;
        tick();
        mem_we   = 1'b0;
        host_req = 1'b0;
        chk("host_rf_ack", {31'b0, host_ack}, 32'd1);
        chk("host_rf_old", host_rdata, pre(7));
        tick();
        tick();
        chk("host_rf_new", mem_read_data, 32'h77777777);

        // Tracker: host writes and out-of-window engine writes do not count
        result_clear = 1'b1;
        tick();
        result_clear = 1'b0;
        host_xfer(1'b1, 16'h100, 32'h0BAD0100, rd, lat);
        chk("trk_host_ignored", {27'b0, result_count}, 32'd0);
        mem_we         = 1'b1;
        mem_addr       = 16'h110;
        mem_write_data = 32'h0;
        tick();
        mem_addr = 16'h0FF;
        tick();
        chk("trk_outside_window", {27'b0, result_count}, 32'd0);

        // Tracker: 0x100..0x10F with 0x105 rewritten
        for (int k = 0; k < 17; k++) begin
            mem_addr       = trk_addr[k];
            mem_write_data = 32'hD0000000 | 32'(k);
            tick();
            chk("trk_count", {27'b0, result_count}, {27'b0, trk_cnt[k]});
            chk("trk_valid", {31'b0, result_valid}, (k == 16) ? 32'd1 : 32'd0);
        end

        // Clear coinciding with a window write: clear wins
        mem_addr     = 16'h100;
        result_clear = 1'b1;
        tick();
        chk("clear_wins_count", {27'b0, result_count}, 32'd0);
        chk("clear_wins_valid", {31'b0, result_valid}, 32'd0);
        result_clear = 1'b0;
        mem_addr     = 16'h101;
        tick();
        chk("after_clear_count", {27'b0, result_count}, 32'd1);
        mem_we = 1'b0;

        // Window near 16'hFFFF must not wrap onto low addresses
        result_base  = 16'hFFF8;
        result_clear = 1'b1;
        tick();
        result_clear   = 1'b0;
        mem_we         = 1'b1;
        mem_addr       = 16'd2;
        mem_write_data = pre(2);
        tick();
        chk("no_wrap_count", {27'b0, result_count}, 32'd0);
        result_base    = 16'h100;
        mem_addr       = 16'h102;
        mem_write_data = 32'h0;
        tick();
        chk("count_before_reset", {27'b0, result_count}, 32'd1);

        // Out-of-range engine access
        mem_addr       = 16'h0400;
        mem_write_data = 32'h12345678;
        tick();
        chk("oor_read_data", mem_read_data, 32'hDEADBEEF);
        chk("oor_addr_err", {31'b0, addr_err}, 32'd1);
        mem_we   = 1'b0;
        mem_addr = 16'd0;
        tick();
        tick();
        chk("oor_write_dropped", mem_read_data, pre(0));
        chk("addr_err_sticky", {31'b0, addr_err}, 32'd1);

        // Reset with result_clear, mid host write to address 1
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 16'd1;
        host_wdata = 32'hBAD0BAD0;
        tick();
        reset        = 1'b1;
        result_clear = 1'b1;
        host_req     = 1'b0;
        tick();
        chk("rst2_mem_read_data", mem_read_data, 32'h0);
        chk("rst2_host_rdata", host_rdata, 32'h0);
        chk("rst2_host_ack", {31'b0, host_ack}, 32'h0);
        chk("rst2_result_count", {27'b0, result_count}, 32'h0);
        chk("rst2_result_valid", {31'b0, result_valid}, 32'h0);
        chk("rst2_addr_err", {31'b0, addr_err}, 32'h0);
        reset        = 1'b0;
        result_clear = 1'b0;
        mem_addr     = 16'd0;
        tick();
        chk("keep_word0", mem_read_data, pre(0));
        mem_addr = 16'd1;
        tick();
        chk("aborted_write_word1", mem_read_data, pre(1));
        chk("no_ack_after_abort", {31'b0, host_ack}, 32'h0);
        mem_addr = 16'd3;
        tick();
        chk("keep_word3", mem_read_data, pre(3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
